// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte controller and the bit-level PHY:
// bit-command encodings, byte FSM states and the state-to-command mapping.
package i2c_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    // The ACK phase runs in the opposite direction to the data phase.
    function automatic logic [3:0] stateCmd(input state_t s, input logic isWrite);
        case (s)
            ST_START: return CMD_START;
            ST_WRITE: return CMD_WRITE;
            ST_READ:  return CMD_READ;
            ST_ACK:   return isWrite ? CMD_READ : CMD_WRITE;
            ST_STOP:  return CMD_STOP;
            default:  return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/i2c_mst_byte_ctrl_if.sv
// Host command/status and PHY bit-command signals of the I2C byte controller.
interface i2c_mst_byte_ctrl_if;

    logic       ena;
    logic       go;
    logic       ready;
    logic       sta;
    logic       sto;
    logic       rd;
    logic       wr;
    logic       ack_in;
    logic [7:0] txd;
    logic [7:0] rxd;
    logic       ack_out;
    logic       done;
    logic       i2c_al;
    logic       timeout;
    logic [3:0] phy_cmd;
    logic       phy_din;
    logic       phy_cmd_ack;
    logic       phy_al;
    logic       phy_dout;

    modport slave (
        input  ena, go, sta, sto, rd, wr, ack_in, txd,
        input  phy_cmd_ack, phy_al, phy_dout,
        output ready, rxd, ack_out, done, i2c_al, timeout, phy_cmd, phy_din
    );

    modport master (
        output ena, go, sta, sto, rd, wr, ack_in, txd,
        output phy_cmd_ack, phy_al, phy_dout,
        input  ready, rxd, ack_out, done, i2c_al, timeout, phy_cmd, phy_din
    );

endinterface

// File: rtl/i2c_mst_byte_ctrl.sv
// Byte-level I2C master sequencer: turns one host byte command into PHY bit commands.
// Optional bit-command watchdog enabled by defining I2C_BYTE_CTRL_TIMEOUT_EN.
module i2c_mst_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input logic                clk,
    input logic                rst,
    i2c_mst_byte_ctrl_if.slave bus
);

    state_t     r_state, w_state;
    logic       r_sto, w_sto;
    logic       r_rd, w_rd;
    logic       r_wr, w_wr;
    logic       r_ackIn, w_ackIn;
    logic [7:0] r_shift, w_shift;
    logic [2:0] r_cnt, w_cnt;
    logic       r_ready, w_ready;
    logic [7:0] r_rxd, w_rxd;
    logic       r_ackOut, w_ackOut;
    logic       r_done, w_done;
    logic       r_al, w_al;
    logic       r_timeout, w_timeout;
    logic [3:0] r_phyCmd, w_phyCmd;
    logic       r_phyDin, w_phyDin;
    logic       w_wdogHit;

`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wdog;

    // Every bit command is preceded by a NOP cycle, so clearing on NOP restarts the count per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_wdog <= '0;
        else if (r_phyCmd == CMD_NOP)  r_wdog <= '0;
        else                           r_wdog <= r_wdog + 1'b1;
    end

    assign w_wdogHit = (r_phyCmd != CMD_NOP) && (r_wdog == TIMEOUT_CYCLES - 1'b1);
`else
    logic w_unusedCfg;
    assign w_unusedCfg = ^TIMEOUT_CYCLES;
    assign w_wdogHit   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sto     <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_ackIn   <= 1'b0;
            r_shift   <= 8'h00;
            r_cnt     <= 3'd0;
            r_ready   <= 1'b0;
            r_rxd     <= 8'h00;
            r_ackOut  <= 1'b0;
            r_done    <= 1'b0;
            r_al      <= 1'b0;
            r_timeout <= 1'b0;
            r_phyCmd  <= CMD_NOP;
            r_phyDin  <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_sto     <= w_sto;
            r_rd      <= w_rd;
            r_wr      <= w_wr;
            r_ackIn   <= w_ackIn;
            r_shift   <= w_shift;
            r_cnt     <= w_cnt;
            r_ready   <= w_ready;
            r_rxd     <= w_rxd;
            r_ackOut  <= w_ackOut;
            r_done    <= w_done;
            r_al      <= w_al;
            r_timeout <= w_timeout;
            r_phyCmd  <= w_phyCmd;
            r_phyDin  <= w_phyDin;
        end
    end

    // Abort sources take priority: enable, then arbitration loss, then watchdog.
    always_comb begin
        w_state   = r_state;
        w_sto     = r_sto;
        w_rd      = r_rd;
        w_wr      = r_wr;
        w_ackIn   = r_ackIn;
        w_shift   = r_shift;
        w_cnt     = r_cnt;
        w_rxd     = r_rxd;
        w_ackOut  = r_ackOut;
        w_done    = 1'b0;
        w_al      = 1'b0;
        w_timeout = 1'b0;
        w_phyCmd  = r_phyCmd;
        w_phyDin  = r_phyDin;

        if (!bus.ena) begin
            w_state  = ST_IDLE;
            w_phyCmd = CMD_NOP;
        end else if (bus.phy_al) begin
            w_state  = ST_IDLE;
            w_phyCmd = CMD_NOP;
            w_al     = 1'b1;
        end else if (w_wdogHit) begin
            w_state   = ST_IDLE;
            w_phyCmd  = CMD_NOP;
            w_timeout = 1'b1;
        end else if (r_state == ST_IDLE) begin
            if (bus.go && r_ready) begin
                w_sto   = bus.sto;
                w_rd    = bus.rd;
                w_wr    = bus.wr;
                w_ackIn = bus.ack_in;
                w_shift = bus.txd;
                w_cnt   = 3'd7;
                if (bus.sta)      w_state = ST_START;
                else if (bus.wr)  w_state = ST_WRITE;
                else if (bus.rd)  w_state = ST_READ;
                else if (bus.sto) w_state = ST_STOP;
                else              w_done  = 1'b1;
            end
        end else if (r_phyCmd == CMD_NOP) begin
            w_phyCmd = stateCmd(r_state, r_wr);
            if (r_state == ST_WRITE)             w_phyDin = r_shift[7];
            else if (r_state == ST_ACK && !r_wr) w_phyDin = r_ackIn;
            else                                 w_phyDin = 1'b1;
        end else if (bus.phy_cmd_ack) begin
            w_phyCmd = CMD_NOP;
            case (r_state)
                ST_START: begin
                    if (r_wr)       w_state = ST_WRITE;
                    else if (r_rd)  w_state = ST_READ;
                    else if (r_sto) w_state = ST_STOP;
                    else begin
                        w_state = ST_IDLE;
                        w_done  = 1'b1;
                    end
                end
                ST_WRITE, ST_READ: begin
                    w_shift = {r_shift[6:0], (r_state == ST_READ) ? bus.phy_dout : 1'b0};
                    w_cnt   = r_cnt - 3'd1;
                    if (r_cnt == 3'd0) w_state = ST_ACK;
                end
                ST_ACK: begin
                    if (r_wr) w_ackOut = bus.phy_dout;
                    else      w_rxd    = r_shift;
                    if (r_sto) w_state = ST_STOP;
                    else begin
                        w_state = ST_IDLE;
                        w_done  = 1'b1;
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                    w_done  = 1'b1;
                end
            endcase
        end

        w_ready = (w_state == ST_IDLE) && bus.ena;
    end

    assign bus.ready   = r_ready;
    assign bus.rxd     = r_rxd;
    assign bus.ack_out = r_ackOut;
    assign bus.done    = r_done;
    assign bus.i2c_al  = r_al;
    assign bus.timeout = r_timeout;
    assign bus.phy_cmd = r_phyCmd;
    assign bus.phy_din = r_phyDin;

endmodule

// File: tb/tb_i2c_mst_byte_ctrl.sv
// Self-checking bench for i2c_mst_byte_ctrl: table-driven byte commands against a
// simple PHY responder, plus arbitration-loss, watchdog and reset sequences.
module tb_i2c_mst_byte_ctrl;
   import i2c_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   i2c_mst_byte_ctrl_if bus();

   i2c_mst_byte_ctrl #(
      .TIMEOUT_W     (16),
      .TIMEOUT_CYCLES(16'd16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic       sta, sto, rd, wr, ackIn;
      logic [7:0] txd;
      logic [7:0] phyBits;
      logic       ackBit;
      logic       goSpam;
      int         nCmds;
      logic [3:0] firstCmd;
      logic [3:0] lastCmd;
      logic       chkAckDin;
      logic       ackDin;
      logic [7:0] expRxd;
      logic       expAckOut;
   } vec_t;

   vec_t vecs[9];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mkVec(input logic sta, sto, rd, wr, ackIn,
                                  input logic [7:0] txd, phyBits,
                                  input logic ackBit, goSpam, input int nCmds,
                                  input logic [3:0] firstCmd, lastCmd,
                                  input logic chkAckDin, ackDin,
                                  input logic [7:0] expRxd, input logic expAckOut);
      vec_t v;
      v.sta = sta; v.sto = sto; v.rd = rd; v.wr = wr; v.ackIn = ackIn;
      v.txd = txd; v.phyBits = phyBits; v.ackBit = ackBit; v.goSpam = goSpam;
      v.nCmds = nCmds; v.firstCmd = firstCmd; v.lastCmd = lastCmd;
      v.chkAckDin = chkAckDin; v.ackDin = ackDin;
      v.expRxd = expRxd; v.expAckOut = expAckOut;
      return v;
   endfunction

   // Compares one observed value against its expected value and logs a failure line.
   task automatic checkOutput(input string name, input logic [31:0] actVal, input logic [31:0] expVal);
      checks++;
      if (actVal !== expVal) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actVal, expVal);
      end
   endtask

   // Presents a host command and raises go for one cycle starting at the next falling edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      bus.sta    = v.sta;
      bus.sto    = v.sto;
      bus.rd     = v.rd;
      bus.wr     = v.wr;
      bus.ack_in = v.ackIn;
      bus.txd    = v.txd;
      bus.go     = 1'b1;
   endtask

   // Runs one command to completion while acting as the PHY, then checks what was seen.
   task automatic runVector(input int idx, input vec_t v);
      int         nCmds = 0;
      int         firstCyc = -1;
      int         doneCnt = 0;
      int         gapErr = 0;
      int         ridx = 0;
      int         widx = 0;
      int         cyc = 0;
      int         after = -1;
      logic [3:0] firstCmd = CMD_NOP;
      logic [3:0] lastCmd = CMD_NOP;
      logic [7:0] wbyte = 8'h00;
      logic       ackDin = 1'bx;
      logic       readyAtDone = 1'b0;
      logic       ackHigh = 1'b0;
      applyStimulus(v);
      while (cyc < 120 && after != 0) begin
         @(negedge clk);
         cyc++;
         bus.go  = v.goSpam && cyc >= 3 && cyc <= 6;
         bus.sta = bus.go ? 1'b1 : v.sta;
         if (bus.done) begin
            doneCnt++;
            readyAtDone = bus.ready;
            if (after < 0) after = 3;
         end
         if (ackHigh) begin
            bus.phy_cmd_ack = 1'b0;
            ackHigh = 1'b0;
            if (bus.phy_cmd != CMD_NOP) gapErr++;
         end else if (bus.phy_cmd != CMD_NOP) begin
            nCmds++;
            if (firstCyc < 0) begin
               firstCyc = cyc;
               firstCmd = bus.phy_cmd;
            end
            lastCmd = bus.phy_cmd;
            bus.phy_dout = 1'b0;
            if (bus.phy_cmd == CMD_WRITE) begin
               if (v.wr && widx < 8) begin
                  wbyte = {wbyte[6:0], bus.phy_din};
                  widx++;
               end else begin
                  ackDin = bus.phy_din;
               end
            end
            if (bus.phy_cmd == CMD_READ) begin
               if (v.wr) begin
                  bus.phy_dout = v.ackBit;
               end else if (ridx < 8) begin
                  bus.phy_dout = v.phyBits[7-ridx];
                  ridx++;
               end
            end
            bus.phy_cmd_ack = 1'b1;
            ackHigh = 1'b1;
         end
         if (after > 0) after--;
      end
      bus.go = 1'b0;
      bus.sta = 1'b0;
      bus.phy_cmd_ack = 1'b0;
      checkOutput($sformatf("v%0d.nCmds", idx), nCmds, v.nCmds);
      checkOutput($sformatf("v%0d.doneCount", idx), doneCnt, 1);
      checkOutput($sformatf("v%0d.readyAtDone", idx), {31'd0, readyAtDone}, 1);
      checkOutput($sformatf("v%0d.nopGap", idx), gapErr, 0);
      checkOutput($sformatf("v%0d.rxd", idx), {24'd0, bus.rxd}, {24'd0, v.expRxd});
      checkOutput($sformatf("v%0d.ackOut", idx), {31'd0, bus.ack_out}, {31'd0, v.expAckOut});
      if (v.nCmds > 0) begin
         checkOutput($sformatf("v%0d.firstCmdCycle", idx), firstCyc, 2);
         checkOutput($sformatf("v%0d.firstCmd", idx), {28'd0, firstCmd}, {28'd0, v.firstCmd});
         checkOutput($sformatf("v%0d.lastCmd", idx), {28'd0, lastCmd}, {28'd0, v.lastCmd});
      end
      if (v.wr) checkOutput($sformatf("v%0d.writeBits", idx), {24'd0, wbyte}, {24'd0, v.txd});
      if (v.chkAckDin) checkOutput($sformatf("v%0d.ackDin", idx), {31'd0, ackDin}, {31'd0, v.ackDin});
   endtask

   // Checks every DUT output against its reset value.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".ready"},   {31'd0, bus.ready},   0);
      checkOutput({tag, ".rxd"},     {24'd0, bus.rxd},     0);
      checkOutput({tag, ".ackOut"},  {31'd0, bus.ack_out}, 0);
      checkOutput({tag, ".done"},    {31'd0, bus.done},    0);
      checkOutput({tag, ".i2cAl"},   {31'd0, bus.i2c_al},  0);
      checkOutput({tag, ".timeout"}, {31'd0, bus.timeout}, 0);
      checkOutput({tag, ".phyCmd"},  {28'd0, bus.phy_cmd}, {28'd0, CMD_NOP});
      checkOutput({tag, ".phyDin"},  {31'd0, bus.phy_din}, 1);
   endtask

   initial begin
      int   cyc;
      int   wcnt;
      int   rcnt;
      int   firstCyc;
      int   toCyc;
      int   toCount;
      int   alCount;
      int   doneCount;
      int   extraCmds;
      logic ackHigh;
      logic hit;
      logic toReady;
      logic [3:0] toCmd;
      vec_t v;

      vecs[0] = mkVec(1,1,0,1,0, 8'hA5, 8'h00, 0,0, 11, CMD_START, CMD_STOP,  0,0, 8'h00, 0);
      vecs[1] = mkVec(0,0,1,0,1, 8'h00, 8'h3C, 0,0,  9, CMD_READ,  CMD_WRITE, 1,1, 8'h3C, 0);
      vecs[2] = mkVec(0,0,0,1,0, 8'h5A, 8'h00, 1,0,  9, CMD_WRITE, CMD_READ,  0,0, 8'h3C, 1);
      vecs[3] = mkVec(1,1,1,0,0, 8'h00, 8'hC3, 0,0, 11, CMD_START, CMD_STOP,  1,0, 8'hC3, 1);
      vecs[4] = mkVec(0,1,0,0,0, 8'h00, 8'h00, 0,0,  1, CMD_STOP,  CMD_STOP,  0,0, 8'hC3, 1);
      vecs[5] = mkVec(0,0,0,0,0, 8'h00, 8'h00, 0,0,  0, CMD_NOP,   CMD_NOP,   0,0, 8'hC3, 1);
      vecs[6] = mkVec(0,0,1,1,0, 8'h81, 8'hFF, 0,0,  9, CMD_WRITE, CMD_READ,  0,0, 8'hC3, 0);
      vecs[7] = mkVec(0,0,0,1,0, 8'h0F, 8'h00, 0,1,  9, CMD_WRITE, CMD_READ,  0,0, 8'hC3, 0);
      vecs[8] = mkVec(0,0,0,1,0, 8'h00, 8'h00, 1,0,  9, CMD_WRITE, CMD_READ,  0,0, 8'h00, 1);

      rst = 1'b1;
      bus.ena = 1'b1;
      bus.go = 1'b0;
      bus.sta = 1'b0;
      bus.sto = 1'b0;
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      bus.ack_in = 1'b0;
      bus.txd = 8'h00;
      bus.phy_cmd_ack = 1'b0;
      bus.phy_al = 1'b0;
      bus.phy_dout = 1'b0;

      @(negedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postReset.ready", {31'd0, bus.ready}, 1);

      for (int i = 0; i < 8; i++) runVector(i, vecs[i]);

      // Arbitration lost together with the 4th WRITE acknowledge.
      $display("[TB] arbitration-loss sequence");
      v = mkVec(0,0,0,1,0, 8'h55, 8'h00, 0,0, 0, CMD_NOP, CMD_NOP, 0,0, 8'h00, 0);
      applyStimulus(v);
      cyc = 0; wcnt = 0; ackHigh = 1'b0; hit = 1'b0; doneCount = 0;
      while (cyc < 100 && !hit) begin
         @(negedge clk);
         cyc++;
         bus.go = 1'b0;
         if (bus.done) doneCount++;
         if (ackHigh) begin
            bus.phy_cmd_ack = 1'b0;
            bus.phy_al = 1'b0;
            ackHigh = 1'b0;
            if (wcnt == 4) begin
               hit = 1'b1;
               checkOutput("al.phyCmdNop", {28'd0, bus.phy_cmd}, {28'd0, CMD_NOP});
               checkOutput("al.pulse", {31'd0, bus.i2c_al}, 1);
               checkOutput("al.ready", {31'd0, bus.ready}, 1);
            end
         end else if (bus.phy_cmd != CMD_NOP) begin
            if (bus.phy_cmd == CMD_WRITE) wcnt++;
            bus.phy_dout = 1'b0;
            bus.phy_cmd_ack = 1'b1;
            bus.phy_al = (wcnt == 4);
            ackHigh = 1'b1;
         end
      end
      checkOutput("al.reached", {31'd0, hit}, 1);
      alCount = 0; extraCmds = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.i2c_al) alCount++;
         if (bus.done) doneCount++;
         if (bus.phy_cmd != CMD_NOP) extraCmds++;
      end
      checkOutput("al.singlePulse", alCount, 0);
      checkOutput("al.noDone", doneCount, 0);
      checkOutput("al.noMoreCmds", extraCmds, 0);
      checkOutput("al.rxdKept", {24'd0, bus.rxd}, 32'hC3);
      checkOutput("al.ackOutKept", {31'd0, bus.ack_out}, 0);

      // PHY never acknowledges.
      $display("[TB] watchdog sequence");
      v = mkVec(0,0,0,1,0, 8'h33, 8'h00, 0,0, 0, CMD_NOP, CMD_NOP, 0,0, 8'h00, 0);
      applyStimulus(v);
      cyc = 0; firstCyc = -1; toCyc = -1; toCount = 0; doneCount = 0;
      toReady = 1'b0; toCmd = 4'hF;
      while (cyc < 60) begin
         @(negedge clk);
         cyc++;
         bus.go = 1'b0;
         if (bus.phy_cmd != CMD_NOP && firstCyc < 0) firstCyc = cyc;
         if (bus.done) doneCount++;
         if (bus.timeout) begin
            toCount++;
            if (toCyc < 0) begin
               toCyc = cyc;
               toReady = bus.ready;
               toCmd = bus.phy_cmd;
            end
         end
      end
      checkOutput("wd.firstCmdCycle", firstCyc, 2);
      checkOutput("wd.noDone", doneCount, 0);
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
      checkOutput("wd.latency", toCyc - firstCyc, 16);
      checkOutput("wd.pulseCount", toCount, 1);
      checkOutput("wd.readyAtTimeout", {31'd0, toReady}, 1);
      checkOutput("wd.cmdAtTimeout", {28'd0, toCmd}, {28'd0, CMD_NOP});
`else
      checkOutput("wd.pulseCount", toCount, 0);
      checkOutput("wd.stillBusy", {31'd0, bus.ready}, 0);
      checkOutput("wd.cmdHeld", {28'd0, bus.phy_cmd}, {28'd0, CMD_WRITE});
`endif
      bus.ena = 1'b0;
      @(negedge clk);
      checkOutput("abort.phyCmd", {28'd0, bus.phy_cmd}, {28'd0, CMD_NOP});
      checkOutput("abort.readyLow", {31'd0, bus.ready}, 0);
      checkOutput("abort.noDone", {31'd0, bus.done}, 0);
      bus.ena = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort.readyBack", {31'd0, bus.ready}, 1);

      // Reset asserted while the 5th READ bit is on the PHY.
      $display("[TB] mid-read reset sequence");
      v = mkVec(0,0,1,0,0, 8'h00, 8'h96, 0,0, 0, CMD_NOP, CMD_NOP, 0,0, 8'h00, 0);
      applyStimulus(v);
      cyc = 0; rcnt = 0; ackHigh = 1'b0; hit = 1'b0;
      while (cyc < 100 && !hit) begin
         @(negedge clk);
         cyc++;
         bus.go = 1'b0;
         if (ackHigh) begin
            bus.phy_cmd_ack = 1'b0;
            ackHigh = 1'b0;
         end else if (bus.phy_cmd == CMD_READ) begin
            rcnt++;
            if (rcnt == 5) begin
               hit = 1'b1;
            end else begin
               bus.phy_dout = v.phyBits[8-rcnt];
               bus.phy_cmd_ack = 1'b1;
               ackHigh = 1'b1;
            end
         end
      end
      checkOutput("rst.reachedBit5", {31'd0, hit}, 1);
      checkOutput("rst.rxdBefore", {24'd0, bus.rxd}, 32'hC3);
      rst = 1'b1;
      #1;
      checkResetOutputs("rst.async");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst.readyAfter", {31'd0, bus.ready}, 1);
      runVector(8, vecs[8]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_mst_byte_ctrl.md
# i2c_mst_byte_ctrl

Byte-level I2C master sequencer sitting between the register/host layer and the I2C PHY (bit controller plus debounce). Accepts one byte command per handshake (optional START, WRITE or READ of 8 bits, ACK phase, optional STOP). It decomposes each command into the PHY's single-bit command/acknowledge protocol, shifting data MSB-first. It reports completion, the received ACK bit and arbitration loss back to the host.

## Interface
- TIMEOUT_W, 16: width of the bit-command watchdog counter (used only with the configuration macro).
- TIMEOUT_CYCLES, 16'hFFFF: clk cycles allowed between issuing a PHY bit command and its acknowledge.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  controller enable; low forces IDLE.
- go  in  1  host command valid.
- ready  out  1  controller can accept a command (IDLE and ena); reset 1'b0.
- sta  in  1  issue START/repeated START before the data phase.
- sto  in  1  issue STOP after the ACK phase.
- rd  in  1  read byte (8 READ bits, then this block drives ACK).
- wr  in  1  write byte (8 WRITE bits, then sample ACK).
- ack_in  in  1  ACK value driven after a read (0 = ACK, 1 = NACK).
- txd  in  8  byte to transmit.
- rxd  out  8  received byte; reset 8'h00.
- ack_out  out  1  ACK sampled after a write (0 = ACK); reset 1'b0.
- done  out  1  one-cycle pulse when the command completes; reset 1'b0.
- i2c_al  out  1  one-cycle arbitration-lost pulse; reset 1'b0.
- timeout  out  1  one-cycle watchdog pulse; reset 1'b0 (tied 0 without macro).
- phy_cmd  out  4  bit command to PHY; reset NOP.
- phy_din  out  1  bit to transmit; reset 1'b1.
- phy_cmd_ack  in  1  PHY one-cycle bit-complete pulse.
- phy_al  in  1  PHY arbitration-lost pulse.
- phy_dout  in  1  received bit, valid in the phy_cmd_ack cycle.

## Operation
- FSM states: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE: go && ready latches sta/sto/rd/wr/ack_in/txd and sets shift register = txd, bit counter = 7. Next state: START if sta; else WRITE if wr; else READ if rd; else STOP if sto; else done pulse and stay IDLE.
- Each non-IDLE state drives its PHY command (START, WRITE, READ or STOP encoding; ACK state uses WRITE with phy_din = ack_in after a read, READ after a write) and holds it until phy_cmd_ack.
- On phy_cmd_ack, phy_cmd returns to NOP for at least one cycle before the next bit command.
- WRITE: phy_din = shift[7]. On each ack the register shifts left, the counter decrements, and WRITE repeats while the counter is not 0; after the 8th ack go to ACK.
- READ: on each ack shift in phy_dout at the LSB, same counting as WRITE.
- ACK: on ack, after a write ack_out <= phy_dout; after a read rxd <= shift. Then go to STOP if sto, else IDLE with done.
- STOP: on ack go to IDLE with done.
- START completes into WRITE, READ or STOP per the latched flags. If both rd and wr are set, wr wins.
- phy_al in any state: phy_cmd <= NOP, go to IDLE, pulse i2c_al, no done, rxd and ack_out unchanged.
- ena low in any state: synchronous abort to IDLE, phy_cmd NOP, no pulses.
- phy_al and phy_cmd_ack in the same cycle: phy_al wins.
- go while ready = 0: ignored; no queuing.

## Timing
- ready drops the cycle after acceptance; the first phy_cmd is valid the cycle after that.
- done pulses the cycle after the final phy_cmd_ack. ready rises in that same cycle.
- Write-only byte costs 9 PHY bit commands. Full sta+wr+sto costs 11. The controller adds 1 cycle of overhead per bit.
- rst asserted mid-operation immediately forces every output to its reset value; no STOP is emitted.

## Configuration
- I2C_BYTE_CTRL_TIMEOUT_EN defined: a counter of TIMEOUT_W bits clears on each new bit command and increments while phy_cmd is not NOP.
  - Reaching TIMEOUT_CYCLES pulses timeout, forces phy_cmd NOP and returns to IDLE without done.
- Macro undefined: no counter is built, timeout is constant 0, and the FSM waits indefinitely.

## Structure
- Shared package i2c_pkg holds:
  - the PHY bit-command encodings (NOP 4'b0000, START 4'b0001, STOP 4'b0010, WRITE 4'b0100, READ 4'b1000), shared with the bit controller;
  - the FSM state enum.
- No sub-module; the shift register, counter and optional watchdog stay inline.

## Test plan
- sta+wr+sto, txd = 8'hA5, PHY model ACKs with SDA = 0 -> PHY sequence START, WRITE bits 1,0,1,0,0,1,0,1, READ(ack), STOP; ack_out = 0; one done pulse.
- rd, ack_in = 1, PHY returns bits 8'h3C -> 8 READs then WRITE with phy_din = 1; rxd = 8'h3C; done pulse.
- phy_al pulsed on the 4th WRITE ack -> phy_cmd NOP next cycle; i2c_al pulses once; no done; ready = 1; rxd unchanged.
- go pulsed again while busy -> ignored; exactly one done; PHY sees exactly one command sequence.
- With macro defined and TIMEOUT_CYCLES = 16, PHY never acks -> timeout pulses 16 cycles after the command issues; FSM returns to IDLE. Without the macro, same stimulus -> stays busy.
- rst asserted during READ bit 5 -> all outputs at reset values immediately; after release a new wr of 8'h00 completes normally.
